// File: rtl/shapool_pkg.sv
// Shared definitions for the shapool job loader: frame geometry, field widths and
// the loader state encoding.
package shapool_pkg;

   localparam int unsigned JOB_FRAME_BYTES = 46;
   localparam int unsigned FRAME_W         = JOB_FRAME_BYTES * 8;
   localparam int unsigned BYTE_CNT_W      = 6;

   localparam int unsigned SHA_STATE_W = 256;
   localparam int unsigned MSG_HEAD_W  = 96;
   localparam int unsigned DIFF_W      = 8;
   localparam int unsigned NONCE_W     = 32;

   typedef enum logic [1:0] {
      StLoad,
      StPrime,
      StRun,
      StDone
   } loader_state_e;

endpackage

// File: rtl/shapool_job_loader_if.sv
// Job frame byte stream plus result readback handshake between a host and the loader.
interface shapool_job_loader_if;
   import shapool_pkg::*;

   logic [7:0]         rx_data;
   logic               rx_valid;
   logic               rx_ready;
   logic               result_ack;
   logic               result_valid;
   logic               result_found;
   logic [NONCE_W-1:0] result_nonce;

   modport master (
      output rx_data, rx_valid, result_ack,
      input  rx_ready, result_valid, result_found, result_nonce
   );

   modport slave (
      input  rx_data, rx_valid, result_ack,
      output rx_ready, result_valid, result_found, result_nonce
   );

endinterface

// File: rtl/shapool_frame_rx.sv
// Byte counter and assembly shift register for the 46-byte job frame. The final byte
// is merged combinationally so the whole frame is presented in its transfer cycle.
module shapool_frame_rx
   import shapool_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_clear,
   input  logic               i_xfer,
   input  logic [7:0]         i_byte,
   output logic               o_frame_done,
   output logic [FRAME_W-1:0] o_frame
);

   localparam logic [BYTE_CNT_W-1:0] LastByte = BYTE_CNT_W'(JOB_FRAME_BYTES - 1);

   logic [FRAME_W-9:0]    r_asm;
   logic [BYTE_CNT_W-1:0] r_byte_cnt;
   logic                  w_last;

   assign w_last       = (r_byte_cnt == LastByte);
   assign o_frame_done = i_xfer && w_last;
   assign o_frame      = {r_asm, i_byte};

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_asm      <= '0;
         r_byte_cnt <= '0;
      end else if (i_xfer) begin
         r_asm      <= {r_asm[FRAME_W-17:0], i_byte};
         r_byte_cnt <= w_last ? '0 : r_byte_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/shapool_job_loader.sv
// Upstream control for shapool: assembles a job frame, pulses the pool through reset,
// supervises the search with a cycle timeout and holds the result until acknowledged.
module shapool_job_loader
   import shapool_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 6400,
   parameter int unsigned TIMEOUT_WIDTH  = 32
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_abort,
   shapool_job_loader_if.slave    bus,
   output logic [SHA_STATE_W-1:0] o_sha_state,
   output logic [MSG_HEAD_W-1:0]  o_message_head,
   output logic [DIFF_W-1:0]      o_difficulty,
   output logic [7:0]             o_nonce_start_msb,
   output logic                   o_pool_reset_n,
   input  logic                   i_pool_success,
   input  logic [NONCE_W-1:0]     i_pool_nonce
);

   loader_state_e r_state, w_state_next;

   logic [TIMEOUT_WIDTH-1:0] r_cycle_cnt;
   logic [SHA_STATE_W-1:0]   r_sha_state;
   logic [MSG_HEAD_W-1:0]    r_message_head;
   logic [DIFF_W-1:0]        r_difficulty;
   logic [7:0]               r_nonce_start_msb;
   logic                     r_result_valid;
   logic                     r_result_found;
   logic [NONCE_W-1:0]       r_result_nonce;

   logic               w_rx_ready;
   logic               w_pool_reset_n;
   logic               w_xfer;
   logic               w_frame_done;
   logic [FRAME_W-1:0] w_frame;
   logic               w_timeout;

   // A byte offered alongside abort is dropped even though rx_ready is high.
   assign w_xfer    = bus.rx_valid && w_rx_ready && !i_abort;
   assign w_timeout = (r_cycle_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

   shapool_frame_rx u_frame_rx (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_clear      (i_abort),
      .i_xfer       (w_xfer),
      .i_byte       (bus.rx_data),
      .o_frame_done (w_frame_done),
      .o_frame      (w_frame)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= StLoad;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (i_abort) begin
         w_state_next = StLoad;
      end else begin
         unique case (r_state)
            StLoad:  if (w_frame_done) w_state_next = StPrime;
            StPrime: w_state_next = StRun;
            StRun:   if (i_pool_success || w_timeout) w_state_next = StDone;
            StDone:  if (bus.result_ack) w_state_next = StLoad;
            default: w_state_next = StLoad;
         endcase
      end
   end

   always_comb begin
      w_rx_ready     = (r_state == StLoad) && !i_reset;
      w_pool_reset_n = (r_state == StRun);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cycle_cnt       <= '0;
         r_sha_state       <= '0;
         r_message_head    <= '0;
         r_difficulty      <= '0;
         r_nonce_start_msb <= '0;
         r_result_valid    <= 1'b0;
         r_result_found    <= 1'b0;
         r_result_nonce    <= '0;
      end else begin
         if (w_frame_done) begin
            r_sha_state       <= w_frame[FRAME_W-1 -: SHA_STATE_W];
            r_message_head    <= w_frame[FRAME_W-SHA_STATE_W-1 -: MSG_HEAD_W];
            r_difficulty      <= w_frame[15:8];
            r_nonce_start_msb <= w_frame[7:0];
         end
         if (r_state == StPrime) begin
            r_cycle_cnt <= '0;
         end else if (r_state == StRun) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
         end
         r_result_valid <= (w_state_next == StDone);
         // Success wins over a coincident timeout.
         if (r_state == StRun && w_state_next == StDone) begin
            r_result_found <= i_pool_success;
            r_result_nonce <= i_pool_success ? i_pool_nonce : '0;
         end
      end
   end

   assign bus.rx_ready     = w_rx_ready;
   assign bus.result_valid = r_result_valid;
   assign bus.result_found = r_result_found;
   assign bus.result_nonce = r_result_nonce;

   assign o_sha_state       = r_sha_state;
   assign o_message_head    = r_message_head;
   assign o_difficulty      = r_difficulty;
   assign o_nonce_start_msb = r_nonce_start_msb;
   assign o_pool_reset_n    = w_pool_reset_n;

endmodule

// File: doc/shapool_job_loader.md
Name: shapool_job_loader

Overview:
- Upstream control stage for shapool. Receives a job frame as a byte stream and assembles it into the parallel job parameters: sha_state, message_head, difficulty, nonce_start_MSB.
- Sequences the pool's reset_n to start a search, supervises it with a cycle timeout, and latches the result (found flag and nonce) for readback until acknowledged.

Parameters:
- TIMEOUT_CYCLES, 6400, RUN cycles before the search is declared unsuccessful (100 nonces x 64 rounds for POOL_SIZE=1).
- TIMEOUT_WIDTH, 32, width of the run cycle counter; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  job frame byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- abort  in  1  discard the current frame or search and return to LOAD.
- result_ack  in  1  consume the latched result.
- sha_state  out  256  to shapool.
- message_head  out  96  to shapool.
- difficulty  out  8  to difficulty_map (low nibble used).
- nonce_start_MSB  out  8  to shapool.
- pool_reset_n  out  1  drives shapool reset_n.
- pool_success  in  1  from shapool success.
- pool_nonce  in  32  from shapool nonce.
- result_valid  out  1  result latched, awaiting ack.
- result_found  out  1  1 = nonce found, 0 = timeout.
- result_nonce  out  32  captured nonce; 0 when not found.

Behaviour:
- Frame: 46 bytes, MSB first.
  - Bytes 0-31: sha_state[255:0].
  - Bytes 32-43: message_head[95:0].
  - Byte 44: difficulty.
  - Byte 45: nonce_start_MSB.
- Reset: state=LOAD; byte_cnt=0; cycle_cnt=0; all job outputs 0; pool_reset_n=0; result_valid=0; result_found=0; result_nonce=0. rx_ready=0 while reset is high.
- rx_ready = (state==LOAD). It is combinational from the state register. A byte transfers when rx_valid && rx_ready.
- LOAD:
  - Each transfer shifts the byte into a 368-bit assembly register (shift left 8, byte enters at LSB) and increments byte_cnt.
  - On the transfer with byte_cnt==45: copy the assembly register to the job output registers, clear byte_cnt, go to PRIME next cycle.
  - Job outputs change only at frame completion. Partial frames never disturb them.
- PRIME (1 cycle): pool_reset_n=0; cycle_cnt cleared; go to RUN.
- RUN: pool_reset_n=1; cycle_cnt increments each cycle.
  - If pool_success=1: result_nonce<=pool_nonce, result_found<=1, go to DONE.
  - Else if cycle_cnt==TIMEOUT_CYCLES-1: result_found<=0, result_nonce<=0, go to DONE.
  - If success and timeout occur in the same cycle, success wins.
- DONE: pool_reset_n=0; result_valid=1 (registered, asserted on the first DONE cycle). result_ack=1 -> LOAD next cycle, result_valid=0.
  - result_found and result_nonce hold until the next DONE entry or reset.
- pool_reset_n is 0 in LOAD, PRIME and DONE, and 1 only in RUN.
- abort (any state, priority over all other transitions except reset): next state LOAD; byte_cnt=0; result_valid=0; pool_reset_n=0. Job outputs and last result are retained.
  - Abort while in LOAD discards the partial frame.
  - A byte offered in the abort cycle is not accepted.
- Bytes offered outside LOAD are not accepted (rx_ready=0). The sender holds them.
- result_ack outside DONE is ignored.
- Reset mid-frame or mid-run: behaves identically to power-on reset.

Decomposition:
- Shared package/include shapool_pkg:
  - JOB_FRAME_BYTES=46.
  - Field widths: SHA_STATE_W=256, MSG_HEAD_W=96, DIFF_W=8, NONCE_W=32.
  - Loader state encoding: LOAD, PRIME, RUN, DONE.
- One sub-module: shapool_frame_rx, the byte counter plus assembly shift register. It outputs frame_done (1-cycle pulse) and frame[367:0]. The FSM, timeout and result capture stay in the top.

Test Plan:
- Load frame dc6a3b8d...fc48d2df, dc141787358b0553535f0119, 03, 00 with rx_valid held high -> rx_ready low from the cycle after byte 45; sha_state=dc6a3b8d_..._fc48d2df; message_head=dc141787_358b0553_535f0119; difficulty=8'h03; nonce_start_MSB=8'h00; pool_reset_n low 1 cycle (PRIME), then high.
- In RUN, force pool_success=1 with pool_nonce=32'h0000_002a at run cycle 10 -> next cycle result_valid=1, result_found=1, result_nonce=32'h2a, pool_reset_n=0; ack -> rx_ready=1.
- Hold pool_success=0 -> exactly 6400 RUN cycles, then result_valid=1, result_found=0, result_nonce=0.
- Assert pool_success on run cycle 6399 (the timeout cycle) -> result_found=1 with the captured nonce.
- Send 10 bytes, pulse abort, then send a full new frame -> outputs reflect only the new frame; previous job outputs unchanged until its completion.
- Offer rx_valid bytes during RUN and DONE -> no transfer, byte_cnt stays 0. Reset asserted mid-RUN -> all outputs at reset values on the next cycle.
